systolic_array_sequencer: RTL and testbench

Control and staging block that drives one monodirectional_systolic_array instance through a complete job.
- Accepts a start command with a vector count.
- Loads ROWS weight rows over a valid/ready stream, pulsing the array's store_weight.
- Streams activation vectors through per-row skew registers into the array.
- De-skews the column results and emits one aligned result vector per input vector, then reports done.

---
 rtl/systolic_array_sequencer.sv | 148 ++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sequencer.sv
// Sequences one systolic-array job: weight load, skewed activation streaming, result deskew, done.
// Latency: a result vector appears ROWS+COLUMNS cycles after its activation vector is accepted.
// Backpressure: w_ready/a_ready come only from the FSM state; the result path has no stall.
module systolic_array_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 2,
   parameter int COLUMNS    = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CNT_WIDTH-1:0]          num_vectors,
   output logic                          busy,
   output logic                          done,
   input  logic                          w_valid,
   output logic                          w_ready,
   input  logic [DATA_WIDTH*COLUMNS-1:0] w_data,
   input  logic                          a_valid,
   output logic                          a_ready,
   input  logic [DATA_WIDTH*ROWS-1:0]    a_data,
   output logic                          r_valid,
   output logic [DATA_WIDTH*COLUMNS-1:0] r_data,
   output logic [DATA_WIDTH*ROWS-1:0]    sa_data,
   output logic [DATA_WIDTH*COLUMNS-1:0] sa_weight,
   output logic                          sa_store_weight,
   input  logic [DATA_WIDTH*COLUMNS-1:0] sa_result
);

   localparam int LAT = ROWS + COLUMNS;
   localparam int WCW = $clog2(ROWS + 1);
   localparam int DCW = $clog2(LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] num_vec_q;
   logic [CNT_WIDTH-1:0] v_cnt_q;
   logic [WCW-1:0]       w_cnt_q;
   logic [DCW-1:0]       d_cnt_q;
   logic [LAT-1:0]       vld_q;
   logic                 w_fire, a_fire, w_last, a_last, zero_job;

   assign w_fire   = w_ready & w_valid;
   assign a_fire   = a_ready & a_valid;
   assign w_last   = (w_cnt_q == WCW'(ROWS - 1));
   assign a_last   = (v_cnt_q == (num_vec_q - CNT_WIDTH'(1)));
   assign zero_job = (num_vec_q == '0);
   assign r_valid  = vld_q[LAT-1];

   // Next-state and handshake outputs; the weight row passes straight through to the array.
   always_comb begin
      state_d         = state_q;
      busy            = (state_q != S_IDLE);
      w_ready         = (state_q == S_LOAD_W);
      a_ready         = (state_q == S_STREAM);
      sa_store_weight = 1'b0;
      sa_weight       = '0;
      done            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD_W;
         end
         S_LOAD_W: begin
            sa_store_weight = w_valid;
            sa_weight       = w_valid ? w_data : '0;
            if (w_valid && w_last) state_d = zero_job ? S_DRAIN : S_STREAM;
         end
         S_STREAM: begin
            if (a_fire && a_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Last result leaves LAT cycles after the final accept, i.e. LAT-1 cycles into DRAIN.
            done = zero_job || (d_cnt_q == DCW'(LAT - 1));
            if (done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, job counters and the valid pipeline that marks real (non-bubble) vectors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         num_vec_q <= '0;
         v_cnt_q   <= '0;
         w_cnt_q   <= '0;
         d_cnt_q   <= '0;
         vld_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) num_vec_q <= num_vectors;
         w_cnt_q <= (state_q == S_LOAD_W) ? (w_cnt_q + WCW'(w_fire)) : '0;
         v_cnt_q <= (state_q == S_STREAM) ? (v_cnt_q + CNT_WIDTH'(a_fire)) : '0;
         d_cnt_q <= (state_q == S_DRAIN) ? (d_cnt_q + DCW'(1)) : '0;
         vld_q   <= {vld_q[LAT-2:0], a_fire};
      end
   end

   // Input skew: row r sees its element r cycles after acceptance; idle cycles inject zeros.
   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic [DATA_WIDTH-1:0] in_el;
      assign in_el = a_fire ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (r == 0) begin : g_row0
         assign sa_data[DATA_WIDTH-1:0] = in_el;
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr_q [r];
         // Shift chain of r stages for this row.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < r; i++) sr_q[i] <= '0;
            end else begin
               sr_q[0] <= in_el;
               for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign sa_data[r*DATA_WIDTH +: DATA_WIDTH] = sr_q[r-1];
      end
   end

   // Output deskew: column c waits COLUMNS-1-c stages, then every column shares one output register.
   for (genvar c = 0; c < COLUMNS; c++) begin : g_deskew
      localparam int D = COLUMNS - 1 - c;
      logic [DATA_WIDTH-1:0] out_q;
      if (D == 0) begin : g_direct
         // Last column arrives latest, so it only needs the output register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) out_q <= '0;
            else        out_q <= sa_result[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] dq [D];
         // Delay chain followed by the output register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) dq[i] <= '0;
               out_q <= '0;
            end else begin
               dq[0] <= sa_result[c*DATA_WIDTH +: DATA_WIDTH];
               for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
               out_q <= dq[D-1];
            end
         end
      end
      assign r_data[c*DATA_WIDTH +: DATA_WIDTH] = out_q;
   end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench for systolic_array_sequencer with a behavioural 2x2 array attached.
// Latency: results are expected ROWS+COLUMNS cycles after each accepted vector.
// Backpressure: the bench waits (bounded) on w_ready/a_ready; results are checked on every r_valid.
module tb_systolic_array_sequencer;
   localparam int DW   = 8;
   localparam int ROWS = 2;
   localparam int COLS = 2;
   localparam int CW   = 16;
   localparam int LAT  = ROWS + COLS;

   localparam logic [DW*COLS-1:0] W0 = {8'd2, 8'd1};   // row0 = [1,2]
   localparam logic [DW*COLS-1:0] W1 = {8'd4, 8'd3};   // row1 = [3,4]
   localparam logic [DW*ROWS-1:0] X1 = {8'd6, 8'd5};   // x = [5,6]

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [CW-1:0]      num_vectors = '0;
   logic               busy, done, w_ready, a_ready, r_valid, sa_store_weight;
   logic               w_valid = 1'b0;
   logic               a_valid = 1'b0;
   logic [DW*COLS-1:0] w_data = '0;
   logic [DW*ROWS-1:0] a_data = '0;
   logic [DW*COLS-1:0] r_data, sa_weight;
   logic [DW*ROWS-1:0] sa_data;
   logic [DW*COLS-1:0] sa_result = '0;

   systolic_array_sequencer #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLUMNS(COLS), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
      .busy(busy), .done(done),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .r_valid(r_valid), .r_data(r_data),
      .sa_data(sa_data), .sa_weight(sa_weight), .sa_store_weight(sa_store_weight),
      .sa_result(sa_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Behavioural array: reconstructs each vector from the skewed rows and applies stored weights.
   logic [DW*ROWS-1:0] hist [64];
   logic [DW-1:0]      aw [ROWS][COLS];
   initial begin
      for (int i = 0; i < 64; i++) hist[i] = '0;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) aw[r][c] = '0;
   end
   always @(negedge clk) begin
      logic [DW-1:0] acc;
      int t;
      hist[cyc % 64] = sa_data;
      if (sa_store_weight) begin
         for (int r = 0; r < ROWS - 1; r++) aw[r] = aw[r+1];
         for (int c = 0; c < COLS; c++) aw[ROWS-1][c] = sa_weight[c*DW +: DW];
      end
      for (int c = 0; c < COLS; c++) begin
         acc = '0;
         t = cyc - ROWS - c;
         if (t >= 0)
            for (int r = 0; r < ROWS; r++) acc = acc + hist[(t + r) % 64][r*DW +: DW] * aw[r][c];
         sa_result[c*DW +: DW] = acc;
      end
   end

   // Scoreboard and event counters.
   typedef struct {logic [DW*COLS-1:0] d; int t;} exp_t;
   exp_t q[$];
   logic [DW*COLS-1:0] last_r = '0;
   int st_cnt = 0, ar_cnt = 0, rv_cnt = 0, done_cnt = 0;
   int last_exp_cyc = 0;
   logic [DW-1:0] tb_w [ROWS][COLS];
   logic [DW*ROWS-1:0] vecs [$];

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sa_store_weight) st_cnt++;
         if (a_ready) ar_cnt++;
         if (done) done_cnt++;
         if (r_valid) begin
            rv_cnt++;
            last_r = r_data;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL spurious_r_valid cyc=%0d r_data=%h, required no r_valid", cyc, r_data);
            end else begin
               e = q.pop_front();
               if (r_data !== e.d || cyc !== e.t) begin
                  bad++;
                  $display("FAIL result got %h at cyc %0d, required %h at cyc %0d", r_data, cyc, e.d, e.t);
               end
            end
         end
      end
   end

   function automatic logic [DW*COLS-1:0] expect_res(input logic [DW*ROWS-1:0] x);
      logic [DW*COLS-1:0] res;
      logic [DW-1:0] acc;
      res = '0;
      for (int c = 0; c < COLS; c++) begin
         acc = '0;
         for (int r = 0; r < ROWS; r++) acc = acc + x[r*DW +: DW] * tb_w[r][c];
         res[c*DW +: DW] = acc;
      end
      return res;
   endfunction

   // Driver tasks; all are entered and left at posedge+1.
   task automatic start_job(input int n);
      start = 1'b1;
      num_vectors = CW'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_w(input logic [DW*COLS-1:0] row0, input logic [DW*COLS-1:0] row1, input bit gap);
      logic [DW*COLS-1:0] rows [ROWS];
      rows[0] = row0;
      rows[1] = row1;
      for (int i = 0; i < ROWS; i++) begin
         if (gap && i > 0) begin
            w_valid = 1'b0;
            @(posedge clk); #1;
         end
         w_valid = 1'b1;
         w_data  = rows[i];
         for (int k = 0; k < 20 && !w_ready; k++) begin @(posedge clk); #1; end
         for (int c = 0; c < COLS; c++) tb_w[i][c] = rows[i][c*DW +: DW];
         @(posedge clk); #1;
      end
      w_valid = 1'b0;
   endtask

   task automatic stream_vecs(input int gap);
      exp_t e;
      foreach (vecs[i]) begin
         if (i > 0) repeat (gap) begin a_valid = 1'b0; @(posedge clk); #1; end
         a_valid = 1'b1;
         a_data  = vecs[i];
         for (int k = 0; k < 20 && !a_ready; k++) begin @(posedge clk); #1; end
         if (a_ready) begin
            e.d = expect_res(vecs[i]);
            e.t = cyc + LAT;
            q.push_back(e);
            last_exp_cyc = e.t;
         end
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
   endtask

   task automatic wait_done(output bit seen, output int dcyc);
      seen = 1'b0;
      dcyc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1'b1; dcyc = cyc; break; end
      end
      @(posedge clk); #1;
   endtask

   // Scenario tasks.
   task automatic test_reset();
      #1;
      total++;
      if ({busy, done, w_ready, a_ready, r_valid, sa_store_weight} !== 6'b0 ||
          {r_data, sa_data, sa_weight} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got ctl=%b data=%h, required all 0",
                  {busy, done, w_ready, a_ready, r_valid, sa_store_weight}, {r_data, sa_data, sa_weight});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({busy, done, w_ready, a_ready, r_valid} !== 5'b0) begin
         bad++;
         $display("FAIL idle_after_reset got %b, required 00000", {busy, done, w_ready, a_ready, r_valid});
      end
   endtask

   task automatic test_single();
      bit seen;
      int dc;
      int rv0 = rv_cnt;
      start_job(1);
      load_w(W0, W1, 1'b0);
      vecs = '{X1};
      stream_vecs(0);
      wait_done(seen, dc);
      total++;
      if (!seen || dc !== last_exp_cyc) begin
         bad++;
         $display("FAIL single_done seen=%0d cyc=%0d, required cyc=%0d", seen, dc, last_exp_cyc);
      end
      total++;
      if (rv_cnt - rv0 !== 1 || last_r !== {8'd34, 8'd23}) begin
         bad++;
         $display("FAIL single_result count=%0d data=%h, required 1 and %h", rv_cnt - rv0, last_r, {8'd34, 8'd23});
      end
   endtask

   task automatic test_stream(input int gap);
      bit seen;
      int dc;
      int rv0 = rv_cnt;
      start_job(3);
      load_w(W0, W1, 1'b0);
      vecs = '{{8'd0, 8'd1}, {8'd1, 8'd0}, {8'd2, 8'd2}};
      stream_vecs(gap);
      wait_done(seen, dc);
      total++;
      if (!seen || dc !== last_exp_cyc) begin
         bad++;
         $display("FAIL stream_done gap=%0d seen=%0d cyc=%0d, required cyc=%0d", gap, seen, dc, last_exp_cyc);
      end
      total++;
      if (rv_cnt - rv0 !== 3 || last_r !== {8'd12, 8'd8} || q.size() !== 0) begin
         bad++;
         $display("FAIL stream_results gap=%0d count=%0d last=%h pending=%0d, required 3 %h 0",
                  gap, rv_cnt - rv0, last_r, q.size(), {8'd12, 8'd8});
      end
   endtask

   task automatic test_w_toggle();
      bit seen;
      int dc;
      int st0 = st_cnt;
      start_job(1);
      load_w(W0, W1, 1'b1);
      total++;
      if (st_cnt - st0 !== 2) begin
         bad++;
         $display("FAIL w_toggle_stores got %0d, required 2", st_cnt - st0);
      end
      vecs = '{X1};
      stream_vecs(0);
      wait_done(seen, dc);
      total++;
      if (!seen || last_r !== {8'd34, 8'd23}) begin
         bad++;
         $display("FAIL w_toggle_result done=%0d data=%h, required 1 %h", seen, last_r, {8'd34, 8'd23});
      end
   endtask

   task automatic test_abort();
      int d0;
      int rv0;
      start_job(3);
      load_w(W0, W1, 1'b0);
      vecs = '{X1, {8'd1, 8'd1}};
      stream_vecs(0);
      a_valid = 1'b1;
      a_data  = {8'd3, 8'd3};
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, w_ready, a_ready, r_valid, sa_store_weight} !== 6'b0 ||
          {r_data, sa_data, sa_weight} !== '0) begin
         bad++;
         $display("FAIL abort_outputs got ctl=%b data=%h, required all 0",
                  {busy, done, w_ready, a_ready, r_valid, sa_store_weight}, {r_data, sa_data, sa_weight});
      end
      a_valid = 1'b0;
      q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      d0  = done_cnt;
      rv0 = rv_cnt;
      repeat (10) begin @(posedge clk); #1; end
      total++;
      if (done_cnt !== d0 || rv_cnt !== rv0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_quiet done=%0d r_valid=%0d busy=%b, required 0 0 0", done_cnt - d0, rv_cnt - rv0, busy);
      end
      test_single();
   endtask

   task automatic test_zero_job();
      bit seen;
      int dc;
      int st0 = st_cnt, ar0 = ar_cnt, rv0 = rv_cnt, d0 = done_cnt;
      start_job(0);
      start = 1'b1;
      num_vectors = CW'(5);
      load_w(W1, W0, 1'b0);
      start = 1'b0;
      wait_done(seen, dc);
      total++;
      if (!seen || done_cnt - d0 !== 1) begin
         bad++;
         $display("FAIL zero_done seen=%0d pulses=%0d, required 1 1", seen, done_cnt - d0);
      end
      total++;
      if (st_cnt - st0 !== 2 || ar_cnt !== ar0 || rv_cnt !== rv0) begin
         bad++;
         $display("FAIL zero_activity stores=%0d a_ready=%0d r_valid=%0d, required 2 0 0",
                  st_cnt - st0, ar_cnt - ar0, rv_cnt - rv0);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_idle busy=%b, required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      int dc;
      start_job(2);
      total++;
      if (busy !== 1'b1 || w_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_start busy=%b w_ready=%b, required 1 1", busy, w_ready);
      end
      load_w({8'd1, 8'd200}, {8'd3, 8'd100}, 1'b0);
      vecs = '{{8'd3, 8'd2}, {8'd255, 8'd255}};
      stream_vecs(0);
      wait_done(seen, dc);
      total++;
      if (!seen || dc !== last_exp_cyc || q.size() !== 0 || last_r !== expect_res({8'd255, 8'd255})) begin
         bad++;
         $display("FAIL b2b_done seen=%0d cyc=%0d pending=%0d last=%h, required cyc=%0d pending=0",
                  seen, dc, q.size(), last_r, last_exp_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream(0);
      test_stream(2);
      test_w_toggle();
      test_abort();
      test_zero_job();
      test_back_to_back();
      repeat (3) @(posedge clk);
      total++;
      if (q.size() !== 0) begin
         bad++;
         $display("FAIL leftover_expected pending=%0d, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d, required completion before time limit", cyc);
      $fatal(1, "watchdog");
   end

endmodule
